// File: rtl/data_mem_arbiter_pkg.sv
// Shared types for the data memory arbiter: FSM encoding and requester indices.
package data_mem_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam int REQ_M0 = 0;
  localparam int REQ_M1 = 1;
endpackage

// File: rtl/data_mem_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the one
// that did not win last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] pick
);
  always_comb begin
    pick = req;
    if (req == 2'b11) pick = last_gnt ? 2'b01 : 2'b10;
  end
endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one single-ported data memory between M0 (CPU) and M1 (DMA) with
// round-robin arbitration, bounded lock bursts and out-of-range blocking.
module data_mem_arbiter
  import data_mem_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 100,
  parameter int MAX_BURST = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic [ADDR_W-1:0] mem_A,
  output logic [DATA_W-1:0] mem_WD,
  output logic              mem_WE,
  input  logic [DATA_W-1:0] mem_RD
);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [3:0]        MAX_B   = 4'(MAX_BURST);

  arb_state_e state, state_nxt;
  logic [3:0] burst_cnt, cnt_nxt;
  logic       last_gnt;

  logic [1:0]             req, we, lock, in_range, pick, gnt_raw, gnt;
  logic [1:0][ADDR_W-1:0] addr;
  logic [1:0][DATA_W-1:0] wdata;
  logic [1:0]             rvalid_q, err_q;
  logic [1:0][DATA_W-1:0] rdata_q;
  logic                   win;

  assign req   = {m1_req, m0_req};
  assign we    = {m1_we, m0_we};
  assign lock  = {m1_lock, m0_lock};
  assign addr  = {m1_addr, m0_addr};
  assign wdata = {m1_wdata, m0_wdata};

  always_comb begin
    for (int i = 0; i < 2; i++) in_range[i] = addr[i] < DEPTH_A;
  end

  rr_arb2 u_rr (
    .req      (req),
    .last_gnt (last_gnt),
    .pick     (pick)
  );

  // An owner keeps the port only while it keeps requesting; a dropped
  // request yields one grant-less cycle back in IDLE.
  always_comb begin
    gnt_raw   = '0;
    state_nxt = IDLE;
    cnt_nxt   = '0;
    case (state)
      IDLE:    gnt_raw = pick;
      OWN0:    gnt_raw[REQ_M0] = req[REQ_M0];
      OWN1:    gnt_raw[REQ_M1] = req[REQ_M1];
      default: gnt_raw = '0;
    endcase
    gnt = gnt_raw & {2{RST}};
    win = gnt_raw[REQ_M1];
    if (|gnt_raw && lock[win] && (burst_cnt + 4'd1 < MAX_B)) begin
      state_nxt = win ? OWN1 : OWN0;
      cnt_nxt   = burst_cnt + 4'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      burst_cnt <= '0;
      last_gnt  <= 1'b1;
    end else begin
      state     <= state_nxt;
      burst_cnt <= cnt_nxt;
      if (|gnt) last_gnt <= win;
    end
  end

  assign m0_gnt = gnt[REQ_M0];
  assign m1_gnt = gnt[REQ_M1];
  assign mem_A  = addr[win];
  assign mem_WD = wdata[win];
  assign mem_WE = (|gnt) & we[win] & in_range[win];

  // Out-of-range reads return zero data with err instead of rvalid.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rvalid_q <= '0;
      err_q    <= '0;
      rdata_q  <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        rvalid_q[i] <= gnt[i] & ~we[i] & in_range[i];
        err_q[i]    <= gnt[i] & ~in_range[i];
        if (gnt[i] && !we[i]) rdata_q[i] <= in_range[i] ? mem_RD : '0;
      end
    end
  end

  assign m0_rvalid = rvalid_q[REQ_M0];
  assign m0_err    = err_q[REQ_M0];
  assign m0_rdata  = rdata_q[REQ_M0];
  assign m1_rvalid = rvalid_q[REQ_M1];
  assign m1_err    = err_q[REQ_M1];
  assign m1_rdata  = rdata_q[REQ_M1];
endmodule
